// File: rtl/alu_reservation_station.sv
// ALU reservation station: collapsing age-ordered queue (slot 0 oldest) that wakes sources from
// writeback tag broadcasts, issues the oldest ready op and squashes ops at/after a ROB restore point.
// dispatch_struct (MSB..LSB): op[4] itype s0{needed ready tag[6]} s1{needed ready tag[6]} dest[6] imm16 ROB[5]
module alu_reservation_station #(
    parameter int RS_DEPTH = 4,
    parameter int NUM_WB   = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  dispatch_valid,
    output logic                  dispatch_ready,
    input  logic [47:0]           dispatch_struct,
    input  logic [NUM_WB-1:0]     wakeup_valid,
    input  logic [NUM_WB*6-1:0]   wakeup_tag,
    input  logic                  kill_valid,
    input  logic [4:0]            kill_ROB_index,
    input  logic [4:0]            ROB_head_index,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [3:0]            issue_op,
    output logic                  issue_itype,
    output logic [5:0]            issue_source_0_tag,
    output logic [5:0]            issue_source_1_tag,
    output logic [5:0]            issue_dest_tag,
    output logic [15:0]           issue_imm16,
    output logic [4:0]            issue_ROB_index
);
    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    localparam int S0_N = 42;
    localparam int S0_R = 41;
    localparam int S0_T = 35;
    localparam int S1_N = 34;
    localparam int S1_R = 33;
    localparam int S1_T = 27;

    logic [RS_DEPTH-1:0][47:0] ent_q, ent_d;
    logic [RS_DEPTH-1:0]       vld_q, vld_d;
    logic [CW-1:0]             count_q, count_d;

    logic [RS_DEPTH-1:0] killed, elig;
    logic [IW-1:0]       sel;
    logic [47:0]         sel_ent;
    logic [4:0]          kill_off;
    logic                fire, accept;

    function automatic logic tag_hit(input logic [5:0] tag, input logic [NUM_WB-1:0] wv,
                                     input logic [NUM_WB*6-1:0] wt);
        logic h;
        h = 1'b0;
        for (int b = 0; b < NUM_WB; b++)
            if (wv[b] && (wt[b*6 +: 6] == tag)) h = 1'b1;
        return h;
    endfunction

    // Age is the distance from the ROB head, so wrap-around indices order correctly.
    assign kill_off = kill_ROB_index - ROB_head_index;

    always_comb begin
        logic [4:0] ent_off;
        ent_off = '0;
        killed  = '0;
        elig    = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_off   = ent_q[i][4:0] - ROB_head_index;
            killed[i] = kill_valid && vld_q[i] && (ent_off >= kill_off);
            elig[i]   = vld_q[i] && !killed[i]
                     && (!ent_q[i][S0_N] || ent_q[i][S0_R])
                     && (!ent_q[i][S1_N] || ent_q[i][S1_R]);
        end
    end

    always_comb begin
        sel         = '0;
        issue_valid = 1'b0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel         = IW'(i);
                issue_valid = 1'b1;
            end
        end
    end

    assign sel_ent            = ent_q[sel];
    assign issue_op           = sel_ent[47:44];
    assign issue_itype        = sel_ent[43];
    assign issue_source_0_tag = sel_ent[S0_T +: 6];
    assign issue_source_1_tag = sel_ent[S1_T +: 6];
    assign issue_dest_tag     = sel_ent[26:21];
    assign issue_imm16        = sel_ent[20:5];
    assign issue_ROB_index    = sel_ent[4:0];

    assign dispatch_ready = (count_q < CW'(RS_DEPTH));
    assign fire           = issue_valid && issue_ready;
    assign accept         = dispatch_valid && dispatch_ready && !kill_valid;

    // Survivors pack down in age order; the new op lands right behind them.
    always_comb begin
        logic [47:0]   cur;
        logic [CW-1:0] pos;
        cur   = '0;
        pos   = '0;
        ent_d = '0;
        vld_d = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            cur = ent_q[i];
            if (tag_hit(cur[S0_T +: 6], wakeup_valid, wakeup_tag)) cur[S0_R] = 1'b1;
            if (tag_hit(cur[S1_T +: 6], wakeup_valid, wakeup_tag)) cur[S1_R] = 1'b1;
            if (vld_q[i] && !killed[i] && !(fire && (sel == IW'(i)))) begin
                ent_d[pos[IW-1:0]] = cur;
                vld_d[pos[IW-1:0]] = 1'b1;
                pos = pos + CW'(1);
            end
        end
        if (accept) begin
            cur = dispatch_struct;
            if (!cur[S0_N] || tag_hit(cur[S0_T +: 6], wakeup_valid, wakeup_tag)) cur[S0_R] = 1'b1;
            if (!cur[S1_N] || tag_hit(cur[S1_T +: 6], wakeup_valid, wakeup_tag)) cur[S1_R] = 1'b1;
            ent_d[pos[IW-1:0]] = cur;
            vld_d[pos[IW-1:0]] = 1'b1;
            pos = pos + CW'(1);
        end
        count_d = pos;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ent_q   <= '0;
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_alu_reservation_station;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        dispatch_valid, dispatch_ready;
    logic [47:0] dispatch_struct;
    logic [1:0]  wakeup_valid;
    logic [11:0] wakeup_tag;
    logic        kill_valid;
    logic [4:0]  kill_ROB_index, ROB_head_index;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_op;
    logic        issue_itype;
    logic [5:0]  issue_source_0_tag, issue_source_1_tag, issue_dest_tag;
    logic [15:0] issue_imm16;
    logic [4:0]  issue_ROB_index;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    alu_reservation_station #(.RS_DEPTH(4), .NUM_WB(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_struct(dispatch_struct),
        .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
        .kill_valid(kill_valid), .kill_ROB_index(kill_ROB_index),
        .ROB_head_index(ROB_head_index),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_itype(issue_itype),
        .issue_source_0_tag(issue_source_0_tag), .issue_source_1_tag(issue_source_1_tag),
        .issue_dest_tag(issue_dest_tag), .issue_imm16(issue_imm16),
        .issue_ROB_index(issue_ROB_index)
    );

    typedef struct {
        logic        dv;
        logic [47:0] ds;
        logic [1:0]  wv;
        logic [5:0]  wt0;
        logic [5:0]  wt1;
        logic        kv;
        logic [4:0]  kidx;
        logic        ir;
        logic        e_iv;
        logic [5:0]  e_dest;
        logic [4:0]  e_rob;
        logic        e_dr;
    } vec_t;

    typedef struct {
        logic [3:0]  op;
        logic        it;
        logic        n0, r0;
        logic [5:0]  t0;
        logic        n1, r1;
        logic [5:0]  t1;
        logic [5:0]  dst;
        logic [15:0] imm;
        logic [4:0]  rob;
    } ment_t;

    function automatic logic [47:0] mk(input logic [3:0] op, input logic it,
                                       input logic n0, input logic r0, input logic [5:0] t0,
                                       input logic n1, input logic r1, input logic [5:0] t1,
                                       input logic [5:0] dst, input logic [15:0] imm,
                                       input logic [4:0] rob);
        return {op, it, n0, r0, t0, n1, r1, t1, dst, imm, rob};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_iv(input string nm, input logic iv, input logic [5:0] dst, input logic [4:0] rob);
        chk({nm, ".issue_valid"}, 32'(issue_valid), 32'(iv));
        if (iv) begin
            chk({nm, ".dest"}, 32'(issue_dest_tag), 32'(dst));
            chk({nm, ".rob"}, 32'(issue_ROB_index), 32'(rob));
        end
    endtask

    task automatic idle();
        dispatch_valid  = 1'b0;
        dispatch_struct = '0;
        wakeup_valid    = '0;
        wakeup_tag      = '0;
        kill_valid      = 1'b0;
        kill_ROB_index  = '0;
        issue_ready     = 1'b0;
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        next();
        nRST = 1'b1;
    endtask

    task automatic disp(input logic [47:0] ds);
        dispatch_valid  = 1'b1;
        dispatch_struct = ds;
    endtask

    function automatic int offs(input logic [4:0] x, input logic [4:0] h);
        return (int'(x) - int'(h) + 32) % 32;
    endfunction

    function automatic logic mhit(input logic [5:0] t, input logic [1:0] wv, input logic [11:0] wt);
        return (wv[0] && (wt[5:0] == t)) || (wv[1] && (wt[11:6] == t));
    endfunction

    task automatic run_random(input int cycles);
        ment_t mq[$];
        ment_t nq[$];
        ment_t ne, e;
        logic  kl[$];
        logic  kil, exp_dr;
        int    k;
        mq = {};
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            if (c % 64 == 0) ROB_head_index = 5'($urandom);
            ne.op  = 4'($urandom);
            ne.it  = 1'($urandom);
            ne.n0  = ($urandom_range(0, 3) != 0);
            ne.r0  = ($urandom_range(0, 2) == 0);
            ne.t0  = 6'($urandom_range(0, 7));
            ne.n1  = ($urandom_range(0, 3) != 0);
            ne.r1  = ($urandom_range(0, 2) == 0);
            ne.t1  = 6'($urandom_range(0, 7));
            ne.dst = 6'($urandom);
            ne.imm = 16'($urandom);
            ne.rob = 5'($urandom);
            dispatch_valid  = ($urandom_range(0, 1) == 1);
            dispatch_struct = mk(ne.op, ne.it, ne.n0, ne.r0, ne.t0, ne.n1, ne.r1, ne.t1,
                                 ne.dst, ne.imm, ne.rob);
            wakeup_valid    = 2'($urandom);
            wakeup_tag      = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            kill_valid      = ($urandom_range(0, 15) == 0);
            kill_ROB_index  = 5'($urandom);
            issue_ready     = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            exp_dr = (mq.size() < 4);
            k = -1;
            kl = {};
            for (int j = 0; j < mq.size(); j++) begin
                kil = kill_valid && (offs(mq[j].rob, ROB_head_index) >= offs(kill_ROB_index, ROB_head_index));
                kl.push_back(kil);
                if (k < 0 && !kil && (!mq[j].n0 || mq[j].r0) && (!mq[j].n1 || mq[j].r1)) k = j;
            end
            chk("rnd.dispatch_ready", 32'(dispatch_ready), 32'(exp_dr));
            chk("rnd.issue_valid", 32'(issue_valid), 32'(k >= 0));
            if (k >= 0) begin
                chk("rnd.op_itype", 32'({issue_op, issue_itype}), 32'({mq[k].op, mq[k].it}));
                chk("rnd.src_tags", 32'({issue_source_0_tag, issue_source_1_tag}), 32'({mq[k].t0, mq[k].t1}));
                chk("rnd.dest", 32'(issue_dest_tag), 32'(mq[k].dst));
                chk("rnd.imm16", 32'(issue_imm16), 32'(mq[k].imm));
                chk("rnd.rob", 32'(issue_ROB_index), 32'(mq[k].rob));
            end
            nq = {};
            for (int j = 0; j < mq.size(); j++) begin
                if (!kl[j] && !(j == k && issue_ready)) begin
                    e = mq[j];
                    if (mhit(e.t0, wakeup_valid, wakeup_tag)) e.r0 = 1'b1;
                    if (mhit(e.t1, wakeup_valid, wakeup_tag)) e.r1 = 1'b1;
                    nq.push_back(e);
                end
            end
            if (dispatch_valid && exp_dr && !kill_valid) begin
                ne.r0 = ne.r0 || !ne.n0 || mhit(ne.t0, wakeup_valid, wakeup_tag);
                ne.r1 = ne.r1 || !ne.n1 || mhit(ne.t1, wakeup_valid, wakeup_tag);
                nq.push_back(ne);
            end
            mq = nq;
            next();
        end
        idle();
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1'b1, mk(4'h0, 1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1, 6'd6, 6'd40, 16'h0, 5'd3),
                    2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[1]  = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd40, 5'd3, 1'b1};
        tbl[2]  = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[3]  = '{1'b1, mk(4'h1, 1'b0, 1'b1, 1'b0, 6'd9, 1'b0, 1'b0, 6'd0, 6'd41, 16'h0, 5'd4),
                    2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[4]  = '{1'b1, mk(4'h2, 1'b0, 1'b1, 1'b1, 6'd7, 1'b1, 1'b1, 6'd8, 6'd42, 16'h0, 5'd5),
                    2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[5]  = '{1'b0, 48'h0, 2'b10, 6'd0, 6'd9, 1'b0, 5'd0, 1'b1, 1'b1, 6'd42, 5'd5, 1'b1};
        tbl[6]  = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd41, 5'd4, 1'b1};
        tbl[7]  = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[8]  = '{1'b1, mk(4'h3, 1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b0, 6'd12, 6'd43, 16'h0, 5'd6),
                    2'b01, 6'd12, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[9]  = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd43, 5'd6, 1'b1};
        tbl[10] = '{1'b1, mk(4'hA, 1'b1, 1'b0, 1'b0, 6'd33, 1'b0, 1'b0, 6'd34, 6'd44, 16'h1234, 5'd7),
                    2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[11] = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd44, 5'd7, 1'b1};
        tbl[12] = '{1'b1, mk(4'h5, 1'b0, 1'b1, 1'b0, 6'd20, 1'b1, 1'b1, 6'd21, 6'd45, 16'h0, 5'd8),
                    2'b00, 6'd20, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[13] = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[14] = '{1'b0, 48'h0, 2'b01, 6'd20, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};
        tbl[15] = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd45, 5'd8, 1'b1};
        tbl[16] = '{1'b0, 48'h0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b1};

        ROB_head_index = 5'd0;
        idle();
        nRST = 1'b0;
        #2;
        chk("reset.issue_valid", 32'(issue_valid), 32'(0));
        chk("reset.dispatch_ready", 32'(dispatch_ready), 32'(1));
        next();
        nRST = 1'b1;

        // Directed vectors, one row per cycle.
        for (int i = 0; i < 17; i++) begin
            dispatch_valid  = tbl[i].dv;
            dispatch_struct = tbl[i].ds;
            wakeup_valid    = tbl[i].wv;
            wakeup_tag      = {tbl[i].wt1, tbl[i].wt0};
            kill_valid      = tbl[i].kv;
            kill_ROB_index  = tbl[i].kidx;
            issue_ready     = tbl[i].ir;
            @(negedge CLK);
            chk($sformatf("vec%0d.dispatch_ready", i), 32'(dispatch_ready), 32'(tbl[i].e_dr));
            chk_iv($sformatf("vec%0d", i), tbl[i].e_iv, tbl[i].e_dest, tbl[i].e_rob);
            next();
        end

        // Full station: waking slot 2 issues it first, order of the rest is kept.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(mk(4'h6, 1'b0, 1'b1, 1'b0, 6'(20 + i), 1'b0, 1'b0, 6'd0, 6'(50 + i), 16'h0, 5'(10 + i)));
            issue_ready = 1'b1;
            @(negedge CLK);
            chk($sformatf("full.fill%0d.dispatch_ready", i), 32'(dispatch_ready), 32'(1));
            chk_iv($sformatf("full.fill%0d", i), 1'b0, 6'd0, 5'd0);
            next();
        end
        disp(mk(4'h7, 1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 6'd2, 6'd60, 16'h0, 5'd20));
        wakeup_valid = 2'b01;
        wakeup_tag   = {6'd0, 6'd22};
        @(negedge CLK);
        chk("full.wake.dispatch_ready", 32'(dispatch_ready), 32'(0));
        chk_iv("full.wake", 1'b0, 6'd0, 5'd0);
        next();
        wakeup_valid = 2'b00;
        @(negedge CLK);
        chk("full.issue.dispatch_ready", 32'(dispatch_ready), 32'(0));
        chk_iv("full.issue", 1'b1, 6'd52, 5'd12);
        next();
        dispatch_valid = 1'b0;
        wakeup_valid   = 2'b11;
        wakeup_tag     = {6'd21, 6'd20};
        @(negedge CLK);
        chk("full.freed.dispatch_ready", 32'(dispatch_ready), 32'(1));
        chk_iv("full.freed", 1'b0, 6'd0, 5'd0);
        next();
        wakeup_valid = 2'b01;
        wakeup_tag   = {6'd0, 6'd23};
        @(negedge CLK);
        chk_iv("full.order0", 1'b1, 6'd50, 5'd10);
        next();
        wakeup_valid = 2'b00;
        @(negedge CLK);
        chk_iv("full.order1", 1'b1, 6'd51, 5'd11);
        next();
        @(negedge CLK);
        chk_iv("full.order3", 1'b1, 6'd53, 5'd13);
        next();
        @(negedge CLK);
        chk_iv("full.empty", 1'b0, 6'd0, 5'd0);
        chk("full.empty.dispatch_ready", 32'(dispatch_ready), 32'(1));
        idle();

        // Kill across ROB wrap with head at 30.
        do_reset();
        ROB_head_index = 5'd30;
        disp(mk(4'h1, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 6'd0, 6'd30, 16'h0, 5'd30));
        @(negedge CLK); chk("kill.d0.dispatch_ready", 32'(dispatch_ready), 32'(1)); next();
        disp(mk(4'h1, 1'b0, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 6'd0, 6'd31, 16'h0, 5'd31));
        @(negedge CLK); chk("kill.d1.dispatch_ready", 32'(dispatch_ready), 32'(1)); next();
        disp(mk(4'h1, 1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 1'b1, 6'd3, 6'd32, 16'h0, 5'd0));
        @(negedge CLK); chk_iv("kill.d2", 1'b0, 6'd0, 5'd0); next();
        disp(mk(4'h1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 6'd0, 6'd33, 16'h0, 5'd1));
        @(negedge CLK); chk_iv("kill.d3", 1'b1, 6'd32, 5'd0); next();
        disp(mk(4'h2, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd37, 16'h0, 5'd2));
        kill_valid     = 1'b1;
        kill_ROB_index = 5'd0;
        issue_ready    = 1'b1;
        @(negedge CLK);
        chk("kill.k0.dispatch_ready", 32'(dispatch_ready), 32'(0));
        chk_iv("kill.k0", 1'b0, 6'd0, 5'd0);
        next();
        idle();
        disp(mk(4'h1, 1'b0, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 6'd0, 6'd34, 16'h0, 5'd2));
        @(negedge CLK);
        chk("kill.after.dispatch_ready", 32'(dispatch_ready), 32'(1));
        chk_iv("kill.after", 1'b0, 6'd0, 5'd0);
        next();
        disp(mk(4'h1, 1'b0, 1'b1, 1'b0, 6'd6, 1'b0, 1'b0, 6'd0, 6'd35, 16'h0, 5'd3));
        @(negedge CLK); chk("kill.cnt3.dispatch_ready", 32'(dispatch_ready), 32'(1)); next();
        idle();
        kill_valid     = 1'b1;
        kill_ROB_index = 5'd31;
        @(negedge CLK); chk("kill.cnt4.dispatch_ready", 32'(dispatch_ready), 32'(0)); next();
        disp(mk(4'h2, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd36, 16'h0, 5'd31));
        issue_ready = 1'b1;
        @(negedge CLK);
        chk("kill.k1.dispatch_ready", 32'(dispatch_ready), 32'(1));
        chk_iv("kill.k1", 1'b0, 6'd0, 5'd0);
        next();
        idle();
        issue_ready  = 1'b1;
        wakeup_valid = 2'b01;
        wakeup_tag   = {6'd0, 6'd1};
        @(negedge CLK); chk_iv("kill.dropped", 1'b0, 6'd0, 5'd0); next();
        wakeup_valid = 2'b00;
        @(negedge CLK); chk_iv("kill.survivor", 1'b1, 6'd30, 5'd30); next();
        @(negedge CLK);
        chk_iv("kill.empty", 1'b0, 6'd0, 5'd0);
        chk("kill.empty.dispatch_ready", 32'(dispatch_ready), 32'(1));
        idle();

        // Stalled issue holds its outputs; a younger ready op does not overtake it.
        do_reset();
        ROB_head_index = 5'd0;
        disp(mk(4'h7, 1'b1, 1'b1, 1'b1, 6'd11, 1'b1, 1'b1, 6'd12, 6'd33, 16'hBEEF, 5'd9));
        @(negedge CLK); chk_iv("hold.disp", 1'b0, 6'd0, 5'd0); next();
        disp(mk(4'h8, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd34, 16'h0, 5'd10));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_iv($sformatf("hold%0d", i), 1'b1, 6'd33, 5'd9);
            chk($sformatf("hold%0d.op_itype", i), 32'({issue_op, issue_itype}), 32'({4'h7, 1'b1}));
            chk($sformatf("hold%0d.src_tags", i), 32'({issue_source_0_tag, issue_source_1_tag}), 32'({6'd11, 6'd12}));
            chk($sformatf("hold%0d.imm16", i), 32'(issue_imm16), 32'(16'hBEEF));
            next();
            dispatch_valid = 1'b0;
        end
        issue_ready = 1'b1;
        @(negedge CLK); chk_iv("hold.release", 1'b1, 6'd33, 5'd9); next();
        @(negedge CLK); chk_iv("hold.younger", 1'b1, 6'd34, 5'd10); next();
        @(negedge CLK); chk_iv("hold.empty", 1'b0, 6'd0, 5'd0);
        idle();

        run_random(600);

        // Asynchronous reset with a ready entry pending.
        do_reset();
        disp(mk(4'h3, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd55, 16'h0, 5'd4));
        next();
        idle();
        @(negedge CLK);
        chk_iv("areset.before", 1'b1, 6'd55, 5'd4);
        #1 nRST = 1'b0;
        #1;
        chk("areset.issue_valid", 32'(issue_valid), 32'(0));
        chk("areset.dispatch_ready", 32'(dispatch_ready), 32'(1));
        next();
        nRST = 1'b1;
        @(negedge CLK);
        chk_iv("areset.after", 1'b0, 6'd0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Consumer end of the dispatch-to-ALU interface. Receives ALU_RS_input_struct_t from dispatch and holds each op until its needed sources are ready.
- Snoops writeback tag broadcasts to wake up waiting sources.
- Issues the oldest ready op to one ALU pipeline.
- One instance per ALU (DU_ALU_0, DU_ALU_1). Sits between dispatch, the writeback bus and the ALU.

Parameters:
- RS_DEPTH, 4, number of entries.
- NUM_WB, 2, number of writeback wakeup buses snooped.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- nRST  in  1  asynchronous active-low reset.
- dispatch_valid  in  1  dispatch presents an op.
- dispatch_ready  out  1  RS can accept an op this cycle.
- dispatch_struct  in  48 (ALU_RS_input_struct_t)  op, itype, source_0/1 {needed, ready, phys_reg_tag}, dest_phys_reg_tag, imm16, ROB_index.
- wakeup_valid  in  NUM_WB  per-bus broadcast valid.
- wakeup_tag  in  NUM_WB x 6  per-bus phys_reg_tag_t now ready.
- kill_valid  in  1  ROB restore: squash ops at or younger than kill_ROB_index.
- kill_ROB_index  in  5  first killed ROB_index_t.
- ROB_head_index  in  5  current ROB head, used as the age reference.
- issue_valid  out  1  issue fields are valid.
- issue_ready  in  1  ALU accepts the issue this cycle.
- issue_op  out  4  ALU_op_t.
- issue_itype  out  1  use imm16 instead of source_1.
- issue_source_0_tag  out  6  phys reg tag for register-file read.
- issue_source_1_tag  out  6  phys reg tag for register-file read.
- issue_dest_tag  out  6  destination phys reg.
- issue_imm16  out  16  immediate.
- issue_ROB_index  out  5  ROB entry to complete.

Behaviour:
- Reset: all entries invalid, count=0, dispatch_ready=1, issue_valid=0. Reset mid-operation discards all entries immediately.
- Storage: collapsing age-ordered queue; slot 0 is the oldest. Each entry stores the full struct plus valid.
- Dispatch handshake: an op is written when dispatch_valid && dispatch_ready. It goes into the first invalid slot after collapse that cycle.
- dispatch_ready = (count < RS_DEPTH), from registered count only. There is no combinational path from issue_ready.
- Source ready on insert: a source is stored ready if struct.ready=1, OR needed=0, OR its tag matches any valid wakeup_tag in the same cycle (same-cycle bypass).
- Wakeup: each cycle, every valid entry's sources are compared against all NUM_WB buses; on a tag match, ready is set next edge.
- Eligibility: entry valid && (!source_0.needed || source_0.ready) && (!source_1.needed || source_1.ready), using registered ready bits.
- Latency: minimum dispatch-to-issue 1 cycle. Minimum wakeup-to-issue 1 cycle.
- Select: issue_valid=1 when any eligible entry exists that is not killed this cycle. The lowest-index (oldest) such entry drives the issue_* outputs (combinational from registered state and kill inputs).
- Issue handshake: when issue_valid && issue_ready, the selected entry is removed and younger entries shift down one slot. When issue_ready=0, the entry stays and outputs stay stable unless an older entry becomes eligible or the entry is killed.
- Kill age compare: off(x) = (x - ROB_head_index) mod 32. On kill_valid, every entry with off(ROB_index) >= off(kill_ROB_index) is invalidated at the edge and survivors are compacted. A same-cycle dispatch is dropped. Killed entries are excluded from select that cycle.
- Simultaneous issue, dispatch and kill: removal and compaction are applied first; dispatch fills the first free slot after compaction (if not killed).
- Full with simultaneous issue: dispatch_ready is still 0 that cycle. The freed slot is visible the next cycle.
- The ALU_LUI and ALU_LINK ops arrive with needed=0 on both sources and are eligible immediately.

Test Plan:
- Reset, dispatch op ADD src0 tag 5 ready, src1 tag 6 ready, dest 40, ROB 3, issue_ready=1 -> issue_valid=1 next cycle, issue_dest_tag=40, issue_ROB_index=3; RS empty after.
- Dispatch A (src0 tag 9 not ready), then B (all ready); pulse wakeup_tag[1]=9 two cycles later -> B issues first; A issues the cycle after the wakeup.
- Dispatch with src1 tag 12 not ready while wakeup_tag[0]=12 is valid the same cycle -> issues the next cycle with no further wakeup.
- Fill 4 entries with unready sources -> dispatch_ready=0. Wake slot 2 with issue_ready=1 -> slot 2 issues, then dispatch_ready=1 the following cycle and order 0,1,3 is preserved.
- ROB_head_index=30, entries ROB 30, 31, 0, 1; kill_valid with kill_ROB_index=0 -> only 30 and 31 remain; a concurrent dispatch is dropped; count=2.
- Entry ready and issue_valid=1 with issue_ready=0 for 3 cycles -> issue_* held constant; issues on the first cycle issue_ready=1.
